multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, the number of consecutive cycles without mem_ready in a memory-wait state before the block declares a memory error.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 Port list, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  sync active-high reset
- op  in  7  opcode of the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access request
- AdrSrc  out  1  address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC load
- RegWrite  out  1  register file write
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  ALU op class: 00 = add, 01 = sub/branch, 10 = funct-decoded
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- illegal  out  1  sticky flag: unsupported opcode
- mem_err  out  1  sticky flag: memory timeout
- state_o  out  4  current state encoding, for debug

Function
REQ-004 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BEQ, ERROR.
REQ-005 Outputs are Moore-decoded from state; any control output not listed for a state is 0 in that state.
REQ-006 FETCH:
- asserts MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10
- IRWrite and PCWrite assert only in the cycle where mem_ready=1
- stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-007 DECODE:
- asserts ALUSrcA=01, ALUSrcB=01, ALUOp=00
- next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> ERROR with illegal set.
REQ-008 MEMADR:
- asserts ALUSrcA=10, ALUSrcB=01, ALUOp=00
- goes to MEMREAD if op=0000011, otherwise to MEMWRITE.
REQ-009 MEMREAD:
- asserts MemReq=1, AdrSrc=1, ResultSrc=00
- waits for mem_ready, then goes to MEMWB.
REQ-010 MEMWB asserts ResultSrc=01 and RegWrite=1, then goes to FETCH.
REQ-011 MEMWRITE:
- asserts MemReq=1, AdrSrc=1, MemWrite=1, ResultSrc=00
- waits for mem_ready, then goes to FETCH.
REQ-012 EXECR asserts ALUSrcA=10, ALUSrcB=00, ALUOp=10, then goes to ALUWB.
REQ-013 EXECI asserts ALUSrcA=10, ALUSrcB=01, ALUOp=10, then goes to ALUWB.
REQ-014 JAL:
- asserts ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1
- then goes to ALUWB.
REQ-015 ALUWB asserts ResultSrc=00 and RegWrite=1, then goes to FETCH.
REQ-016 BEQ:
- asserts ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00
- PCWrite equals zero
- then goes to FETCH.
REQ-017 ImmSrc is combinational from op in every state: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; otherwise 00.
REQ-018 Wait counter:
- a saturating 4-bit counter increments on each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0
- it clears on every state change
- when the count reaches MEM_TIMEOUT with mem_ready still 0, the next state is ERROR and mem_err sets.
REQ-019 Timeout boundary: if mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT, the access completes normally and no error is raised.
REQ-020 ERROR:
- all control outputs are 0
- the state is held until rst
- illegal and mem_err keep their values.
REQ-021 Instruction latency in cycles, with zero memory wait: lw = 5, sw = 4, R/I/jal = 4, beq = 3.

Reset
REQ-022 With rst=1 at a clock edge, the next state is FETCH; the wait counter, illegal and mem_err clear to 0.
REQ-023 rst overrides every transition, including a reset asserted mid-access and a reset asserted in ERROR.
REQ-024 In the first cycle after reset, MemReq=1 and all write enables are 0 until mem_ready.

Structure
REQ-025 A shared package holds:
- the state enum
- opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL)
- ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings.
REQ-026 One sub-module, imm_src_decoder, implements REQ-017; the FSM, counter and flags live in the top module.

Verification
REQ-027 lw with op=0000011 and mem_ready=1 throughout -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 and ResultSrc=01 only in MEMWB.
REQ-028 beq with op=1100011: zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; ALUOp=01 and ImmSrc=10 in both cases.
REQ-029 sw with mem_ready held low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH; mem_err=0.
REQ-030 mem_ready held low with MEM_TIMEOUT=15 -> ERROR entered after 15 wait cycles, mem_err=1, all controls 0; rst=1 -> FETCH with mem_err=0.
REQ-031 op=1111111 in DECODE -> ERROR, illegal=1, RegWrite and PCWrite stay 0 thereafter.
REQ-032 rst asserted during MEMREAD -> FETCH on the next cycle, with no RegWrite pulse.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared states, opcodes and control encodings
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // States that hold a memory access open until mem_ready.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller/datapath signal bundle
interface multicycle_controller_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       MemReq;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       illegal;
  logic       mem_err;
  logic [3:0] state_o;

  modport master (
    input  op, zero, mem_ready,
    output MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
    output illegal, mem_err, state_o
  );

  modport slave (
    output op, zero, mem_ready,
    input  MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
    input  illegal, mem_err, state_o
  );
endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// rtl/multicycle_controller_imm_src_decoder.sv - immediate format select from opcode
module imm_src_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM with memory timeout
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  // Timeout fires on the wait cycle whose increment would bring the count to MEM_TIMEOUT.
  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       mem_err_q, mem_err_d;

  logic       in_wait;
  logic       timeout;

  logic       mem_req;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  assign in_wait = is_wait_state(state_q) && !bus.mem_ready;
  assign timeout = in_wait && (wait_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    mem_err_d  = mem_err_q;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_ERROR;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        pc_write  = bus.zero;
        state_d   = S_FETCH;
      end
      default: state_d = S_ERROR;
    endcase

    if (timeout) begin
      state_d   = S_ERROR;
      mem_err_d = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_wait && (wait_cnt_q != 4'hF)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  imm_src_decoder u_imm_src_decoder (
    .op_i      (bus.op),
    .imm_src_o (bus.ImmSrc)
  );

  assign bus.MemReq    = mem_req;
  assign bus.AdrSrc    = adr_src;
  assign bus.MemWrite  = mem_write;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.RegWrite  = reg_write;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.illegal   = illegal_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [6:0] legal_ops [6] = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL};

  // {MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  logic [13:0] act_ctrl;
  assign act_ctrl = {bus.MemReq, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                     bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp};

  function automatic logic [13:0] exp_ctrl(state_e s, logic mr, logic z);
    case (s)
      S_FETCH:    return {1'b1, 1'b0, 1'b0, mr, mr, 1'b0, RES_ALURESULT, SRCA_PC, SRCB_FOUR, ALUOP_ADD};
      S_DECODE:   return {6'b0, RES_ALUOUT, SRCA_OLDPC, SRCB_IMM, ALUOP_ADD};
      S_MEMADR:   return {6'b0, RES_ALUOUT, SRCA_RS1, SRCB_IMM, ALUOP_ADD};
      S_MEMREAD:  return {6'b110000, RES_ALUOUT, 6'b0};
      S_MEMWB:    return {6'b000001, RES_DATA, 6'b0};
      S_MEMWRITE: return {6'b111000, RES_ALUOUT, 6'b0};
      S_EXECR:    return {6'b0, RES_ALUOUT, SRCA_RS1, SRCB_RS2, ALUOP_FUNCT};
      S_EXECI:    return {6'b0, RES_ALUOUT, SRCA_RS1, SRCB_IMM, ALUOP_FUNCT};
      S_JAL:      return {6'b000010, RES_ALUOUT, SRCA_OLDPC, SRCB_FOUR, ALUOP_ADD};
      S_ALUWB:    return {6'b000001, RES_ALUOUT, 6'b0};
      S_BEQ:      return {4'b0000, z, 1'b0, RES_ALUOUT, SRCA_RS1, SRCB_RS2, ALUOP_SUB};
      default:    return 14'b0;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(logic [6:0] op);
    if (op == OP_SW)  return IMM_S;
    if (op == OP_BEQ) return IMM_B;
    if (op == OP_JAL) return IMM_J;
    return IMM_I;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Plays one instruction from FETCH with fw fetch waits and mw data-memory waits.
  task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                           input string tag, output int memwrite_cycles);
    state_e path[$];
    logic   rdy[$];
    memwrite_cycles = 0;
    for (int i = 0; i <= fw; i++) begin path.push_back(S_FETCH); rdy.push_back(i == fw); end
    path.push_back(S_DECODE); rdy.push_back(1'($urandom_range(0, 1)));
    if (op == OP_LW || op == OP_SW) begin
      path.push_back(S_MEMADR); rdy.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i <= mw; i++) begin
        path.push_back(op == OP_LW ? S_MEMREAD : S_MEMWRITE);
        rdy.push_back(i == mw);
      end
      if (op == OP_LW) begin path.push_back(S_MEMWB); rdy.push_back(1'($urandom_range(0, 1))); end
    end else if (op == OP_BEQ) begin
      path.push_back(S_BEQ); rdy.push_back(1'($urandom_range(0, 1)));
    end else begin
      path.push_back(op == OP_RTYPE ? S_EXECR : (op == OP_ITYPE ? S_EXECI : S_JAL));
      rdy.push_back(1'($urandom_range(0, 1)));
      path.push_back(S_ALUWB); rdy.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < path.size(); i++) begin
      bus.op = op;
      bus.zero = z;
      bus.mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (bus.MemWrite === 1'b1) memwrite_cycles++;
      if (bus.state_o !== path[i] || act_ctrl !== exp_ctrl(path[i], rdy[i], z) ||
          bus.ImmSrc !== exp_imm(op) || bus.illegal !== 1'b0 || bus.mem_err !== 1'b0) begin
        failures++;
        $display("FAIL %s step %0d: got state=%0d ctrl=%b imm=%b ill=%b merr=%b, want state=%0d ctrl=%b imm=%b ill=0 merr=0",
                 tag, i, bus.state_o, act_ctrl, bus.ImmSrc, bus.illegal, bus.mem_err,
                 path[i], exp_ctrl(path[i], rdy[i], z), exp_imm(op));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    bus.op = OP_LW; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== S_FETCH || act_ctrl !== exp_ctrl(S_FETCH, 1'b0, 1'b0) ||
        bus.illegal !== 1'b0 || bus.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d ctrl=%b ill=%b merr=%b, want state=%0d ctrl=%b ill=0 merr=0",
               bus.state_o, act_ctrl, bus.illegal, bus.mem_err, S_FETCH, exp_ctrl(S_FETCH, 1'b0, 1'b0));
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1 || bus.MemReq !== 1'b1) begin
      failures++;
      $display("FAIL reset_fetch_ready: got IRWrite=%b PCWrite=%b MemReq=%b, want 1 1 1",
               bus.IRWrite, bus.PCWrite, bus.MemReq);
    end
  endtask

  task automatic test_lw();
    int mwc;
    run_instr(OP_LW, 1'b0, 0, 0, "lw", mwc);
    run_instr(OP_LW, 1'b1, 2, 3, "lw_wait", mwc);
  endtask

  task automatic test_beq();
    int mwc;
    run_instr(OP_BEQ, 1'b1, 0, 0, "beq_taken", mwc);
    run_instr(OP_BEQ, 1'b0, 0, 0, "beq_not_taken", mwc);
  endtask

  task automatic test_sw_wait();
    int mwc;
    run_instr(OP_SW, 1'b0, 0, 3, "sw_wait", mwc);
    checks++;
    if (mwc != 4) begin
      failures++;
      $display("FAIL sw_memwrite_cycles: got %0d, want 4", mwc);
    end
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== S_FETCH || bus.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL sw_return: got state=%0d merr=%b, want state=%0d merr=0", bus.state_o, bus.mem_err, S_FETCH);
    end
  endtask

  task automatic test_latency();
    int want [6] = '{5, 4, 4, 4, 3, 4};
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      bus.op = legal_ops[k];
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      do begin
        @(posedge clk); #1;
        n++;
      end while (bus.state_o !== S_FETCH && n < 20);
      checks++;
      if (n != want[k]) begin
        failures++;
        $display("FAIL latency op=%b: got %0d cycles, want %0d", legal_ops[k], n, want[k]);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    int mwc;
    run_instr(OP_LW, 1'b0, 14, 14, "boundary_lw", mwc);
    run_instr(OP_SW, 1'b0, 0, 14, "boundary_sw", mwc);
  endtask

  task automatic test_random();
    int mwc;
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op = legal_ops[$urandom_range(0, 5)];
      int fw = $urandom_range(0, 4);
      int mw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 5);
      run_instr(op, 1'($urandom_range(0, 1)), fw, mw, "random", mwc);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.op = OP_LW;
    for (int i = 0; i < 15; i++) begin
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state_o !== S_FETCH || bus.MemReq !== 1'b1 || bus.mem_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait %0d: got state=%0d MemReq=%b merr=%b, want state=%0d MemReq=1 merr=0",
                 i, bus.state_o, bus.MemReq, bus.mem_err, S_FETCH);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.state_o !== S_ERROR || act_ctrl !== 14'b0 || bus.mem_err !== 1'b1 || bus.illegal !== 1'b0) begin
        failures++;
        $display("FAIL timeout_error %0d: got state=%0d ctrl=%b merr=%b ill=%b, want state=%0d ctrl=0 merr=1 ill=0",
                 i, bus.state_o, act_ctrl, bus.mem_err, bus.illegal, S_ERROR);
      end
      @(posedge clk); #1;
    end
    do_reset();
    #1;
    checks++;
    if (bus.state_o !== S_FETCH || bus.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset: got state=%0d merr=%b, want state=%0d merr=0", bus.state_o, bus.mem_err, S_FETCH);
    end
  endtask

  task automatic test_illegal();
    for (int t = 0; t < 2; t++) begin
      logic [6:0] op = 7'h7F;
      if (t == 1) begin
        do op = 7'($urandom);
        while (op inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL});
      end
      bus.op = op;
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (bus.state_o !== S_ERROR || bus.illegal !== 1'b1 || bus.mem_err !== 1'b0 ||
            bus.RegWrite !== 1'b0 || bus.PCWrite !== 1'b0 || act_ctrl !== 14'b0) begin
          failures++;
          $display("FAIL illegal op=%b cyc %0d: got state=%0d ill=%b merr=%b ctrl=%b, want state=%0d ill=1 merr=0 ctrl=0",
                   op, i, bus.state_o, bus.illegal, bus.mem_err, act_ctrl, S_ERROR);
        end
        @(posedge clk); #1;
      end
      do_reset();
      #1;
      checks++;
      if (bus.state_o !== S_FETCH || bus.illegal !== 1'b0) begin
        failures++;
        $display("FAIL illegal_reset: got state=%0d ill=%b, want state=%0d ill=0", bus.state_o, bus.illegal, S_FETCH);
      end
    end
  endtask

  task automatic test_reset_midaccess();
    int seen_regwrite = 0;
    bus.op = OP_LW;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.state_o !== S_MEMREAD) begin
      failures++;
      $display("FAIL midaccess_setup: got state=%0d, want %0d", bus.state_o, S_MEMREAD);
    end
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    if (bus.RegWrite !== 1'b0) seen_regwrite++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.RegWrite !== 1'b0) seen_regwrite++;
      checks++;
      if (bus.state_o !== S_FETCH) begin
        failures++;
        $display("FAIL midaccess_fetch %0d: got state=%0d, want %0d", i, bus.state_o, S_FETCH);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (seen_regwrite != 0) begin
      failures++;
      $display("FAIL midaccess_regwrite: got %0d RegWrite cycles, want 0", seen_regwrite);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.op = OP_LW;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_beq();
    test_sw_wait();
    test_latency();
    test_timeout_boundary();
    test_random();
    test_timeout();
    test_illegal();
    test_reset_midaccess();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
